// File: rtl/bank_readout_sequencer_pkg.sv
// Shared types and helpers for the four-bank byte readout sequencer.
// State encoding, bank geometry and the index-to-select split.
package bank_readout_sequencer_pkg;

  localparam int unsigned NUM_BANKS      = 4;
  localparam int unsigned BYTES_PER_BANK = 4;
  localparam int unsigned NUM_IDX        = NUM_BANKS * BYTES_PER_BANK;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SELECT  = 3'd1,
    CAPTURE = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_t;

  typedef struct packed {
    logic [1:0] bank;
    logic [1:0] byte_sel;
  } sel_t;

  // Upper two index bits pick the bank, lower two pick the byte lane.
  function automatic sel_t split_idx(input logic [3:0] idx);
    sel_t s;
    s.bank     = idx[3:2];
    s.byte_sel = idx[1:0];
    return s;
  endfunction

endpackage

// File: rtl/bank_readout_sequencer.sv
// Walks a run of byte indices across four 32-bit banks via the byte mux,
// capturing each registered mux byte and streaming it on valid/ready.
module bank_readout_sequencer
  import bank_readout_sequencer_pkg::*;
#(
  parameter int unsigned MUX_LATENCY = 1,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] first_idx,
  input  logic [IDX_W:0]   count,
  output logic [1:0]       bank_sel,
  output logic [1:0]       byte_sel,
  input  logic [7:0]       mux_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned WAIT_W = $clog2(MUX_LATENCY + 1) + 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     rem_q, rem_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [1:0]         bank_sel_d, byte_sel_d;
  logic [7:0]         out_data_d;
  logic               out_valid_d, out_last_d, busy_d, done_d;
  sel_t               start_sel, next_sel;
  logic [IDX_W-1:0]   idx_inc;

  assign idx_inc   = idx_q + 1'b1;
  assign start_sel = split_idx(first_idx);
  assign next_sel  = split_idx(idx_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    wait_d      = wait_q;
    bank_sel_d  = bank_sel;
    byte_sel_d  = byte_sel;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    busy_d      = busy;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          idx_d      = first_idx;
          rem_d      = (count == '0) ? (IDX_W + 1)'(NUM_IDX) : count;
          bank_sel_d = start_sel.bank;
          byte_sel_d = start_sel.byte_sel;
          wait_d     = '0;
          busy_d     = 1'b1;
          state_d    = SELECT;
        end
      end
      // Selects were registered on entry, so they are already stable here.
      SELECT: begin
        if (wait_q == WAIT_W'(MUX_LATENCY)) begin
          state_d = CAPTURE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      CAPTURE: begin
        out_data_d  = mux_data;
        out_valid_d = 1'b1;
        out_last_d  = (rem_q == (IDX_W + 1)'(1));
        state_d     = PRESENT;
      end
      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rem_d       = (rem_q != '0) ? rem_q - 1'b1 : '0;
          if (rem_q == (IDX_W + 1)'(1)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d      = idx_inc;
            bank_sel_d = next_sel.bank;
            byte_sel_d = next_sel.byte_sel;
            wait_d     = '0;
            state_d    = SELECT;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      bank_sel  <= '0;
      byte_sel  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      bank_sel  <= bank_sel_d;
      byte_sel  <= byte_sel_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_bank_readout_sequencer.sv
// Directed bench: sequencer driving a registered four-bank byte mux model.
module tb_bank_readout_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] first_idx;
  logic [4:0] count;
  logic [1:0] bank_sel, byte_sel;
  logic [7:0] mux_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last, busy, done;

  logic [31:0] banks [4];
  logic [7:0]  exp_bytes [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  bank_readout_sequencer #(.MUX_LATENCY(1), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .first_idx(first_idx), .count(count),
    .bank_sel(bank_sel), .byte_sel(byte_sel), .mux_data(mux_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  // Registered byte mux: one edge from select change to valid data.
  always @(posedge clk) begin
    if (rst) mux_data <= '0;
    else     mux_data <= 8'(banks[bank_sel] >> {byte_sel, 3'b000});
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clk);
    chk({tag, "_valid_tmo"}, 32'(out_valid), 32'd1);
  endtask

  task automatic pulse_start(input logic [3:0] f, input logic [4:0] c);
    start = 1'b1; first_idx = f; count = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs n bytes from index f; stall_k stalls that byte 5 cycles,
  // poke_k pulses a stray start while that byte is presented.
  task automatic run_seq(input string tag, input logic [3:0] f, input logic [4:0] c,
                         input int n, input int stall_k, input int poke_k);
    int         d0;
    logic [3:0] idx;
    d0 = done_cnt;
    pulse_start(f, c);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    idx = f;
    for (int k = 0; k < n; k++) begin
      if (k == stall_k) out_ready = 1'b0;
      wait_valid(tag);
      chk({tag, "_data"}, 32'(out_data), 32'(exp_bytes[k]));
      chk({tag, "_last"}, 32'(out_last), 32'(k == n - 1));
      chk({tag, "_sel"}, 32'({bank_sel, byte_sel}), 32'(idx));
      if (k == stall_k) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
          chk({tag, "_hold_d"}, 32'(out_data), 32'(exp_bytes[k]));
        end
        out_ready = 1'b1;
      end
      if (k == poke_k) begin
        start = 1'b1; first_idx = 4'd9; count = 5'd2;
      end
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_vlow"}, 32'(out_valid), 32'd0);
      if (k < n - 1) chk({tag, "_nodone"}, 32'(done), 32'd0);
      idx = idx + 4'd1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_done_end"}, 32'(done), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    banks[0] = 32'h44332211; banks[1] = 32'h88776655;
    banks[2] = 32'hCCBBAA99; banks[3] = 32'h00FFEEDD;
    rst = 1'b1; start = 1'b0; first_idx = '0; count = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel",   32'({bank_sel, byte_sel}), 32'd0);
    chk("rst_data",  32'(out_data), 32'd0);
    chk("rst_ctl",   32'({out_valid, out_last, busy, done}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full 16-byte walk, count 0 meaning 16
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                  8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h00};
    run_seq("full", 4'd0, 5'd0, 16, -1, -1);

    // Wrap 15 -> 0
    exp_bytes[0] = 8'hFF; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h11; exp_bytes[3] = 8'h22;
    run_seq("wrap", 4'd14, 5'd4, 4, -1, -1);
    run_seq("stall", 4'd14, 5'd4, 4, 1, -1);
    run_seq("poke", 4'd14, 5'd4, 4, -1, 0);

    // Latency from start to out_valid
    start = 1'b1; first_idx = 4'd5; count = 5'd1;
    @(negedge clk);
    start = 1'b0;
    chk("lat_sel", 32'({bank_sel, byte_sel}), 32'h5);
    chk("lat_v0", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_v1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_v2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_v3", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h66);
    chk("lat_last", 32'(out_last), 32'd1);
    @(negedge clk);
    chk("lat_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("lat_idle", 32'({busy, done}), 32'd0);

    // Reset while the third byte is presented
    begin
      int d0;
      d0 = done_cnt;
      pulse_start(4'd0, 5'd16);
      wait_valid("rmid0"); @(negedge clk);
      wait_valid("rmid1"); @(negedge clk);
      out_ready = 1'b0;
      wait_valid("rmid2");
      chk("rmid_data", 32'(out_data), 32'h33);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      chk("rmid_v", 32'(out_valid), 32'd0);
      chk("rmid_busy", 32'(busy), 32'd0);
      chk("rmid_done", 32'(done), 32'd0);
      repeat (4) @(negedge clk);
      chk("rmid_nodone", 32'(done_cnt - d0), 32'd0);
      chk("rmid_still_idle", 32'({busy, out_valid}), 32'd0);
    end
    exp_bytes[0] = 8'h11;
    run_seq("after_rst", 4'd0, 5'd1, 1, -1, -1);

    // Reset coincident with start wins
    rst = 1'b1; start = 1'b1; first_idx = 4'd3; count = 5'd2;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    chk("rst_start_idle", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
